regwb_queue: RTL and testbench
==============================

REGWB_QUEUE -- requirements
Module: regwb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning writeback queue entries (power of two, 2..16).
REQ-002 SHALL have parameter NREGS, default 18, meaning architectural registers addressed (g0-g15=0-15, fp=16, sp=17).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wb_valid  input  1  execute stage offers a result.
REQ-006 SHALL have port wb_ready  output  1  queue accepts a result this cycle.
REQ-007 SHALL have port wb_idx  input  5  destination register index.
REQ-008 SHALL have port wb_data  input  64  result value.
REQ-009 SHALL have port rf_we  output  1  write strobe to the register bank.
REQ-010 SHALL have port rf_ready  input  1  register bank consumes the write this cycle.
REQ-011 SHALL have port rf_idx  output  5  register index of the head entry.
REQ-012 SHALL have port rf_data  output  64  data of the head entry.
REQ-013 SHALL have port flush  input  1  synchronous discard of all queued entries.
REQ-014 SHALL have port busy  output  NREGS  per-register pending-write bitmap for decode stalls.
REQ-015 SHALL have port bad_idx  output  1  sticky flag: a result with wb_idx >= NREGS was offered.

Function
REQ-016 SHALL implement an in-order FIFO of DEPTH entries {idx[4:0], data[63:0]} with read/write pointers and an occupancy count 0..DEPTH.
REQ-017 SHALL drive wb_ready = (count != DEPTH) && !flush; no pop-through when full.
REQ-018 SHALL push on a cycle with wb_valid && wb_ready && wb_idx < NREGS.
REQ-019 SHALL drop (not push) a handshaken entry with wb_idx >= NREGS and set bad_idx, which holds until reset.
REQ-020 SHALL drive rf_we = (count != 0); rf_idx/rf_data SHALL show the head entry combinationally from storage (zero when empty).
REQ-021 SHALL pop on a cycle with rf_we && rf_ready; head SHALL hold stable while rf_we && !rf_ready.
REQ-022 SHALL apply push and pop in the same cycle with count unchanged, including at count == DEPTH-... boundaries; at count == 0 a simultaneous push SHALL NOT pop (data visible next cycle, latency 1).
REQ-023 SHALL wrap both pointers modulo DEPTH.
REQ-024 SHALL set busy[r] = 1 iff at least one valid queue entry has idx == r; busy SHALL reflect the registered state (updates the cycle after push/pop).
REQ-025 SHALL, on flush, set count to 0, align pointers to 0 and clear busy next cycle; flush SHALL take priority over simultaneous push and pop; bad_idx SHALL be unaffected.
REQ-026 SHALL keep multiple entries to the same register in order so the last-pushed value is written last.

Reset
REQ-027 SHALL, while reset is low, asynchronously force count=0, pointers=0, bad_idx=0, hence rf_we=0, wb_ready=0, busy=0, rf_idx=0, rf_data=0.
REQ-028 SHALL discard queued entries if reset asserts mid-operation; storage contents need not be cleared.
REQ-029 SHALL assert wb_ready on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place register index constants (G0..G15, FP=16, SP=17, NREGS) and a wb_entry_t struct typedef in the shared CPU package.
REQ-031 SHALL keep the design flat; the FIFO storage/pointer logic MAY be a sub-module named wb_fifo.

Verification
REQ-032 Push idx=3 data=0xDEAD with rf_ready=1 -> next cycle rf_we=1, rf_idx=3, rf_data=0xDEAD, busy[3]=1; following cycle busy[3]=0.
REQ-033 rf_ready=0, push 4 entries -> wb_ready=0 after fourth; fifth offer not accepted; release rf_ready -> entries drain in push order, one per cycle.
REQ-034 Full queue, wb_valid=1 and rf_ready=1 same cycle -> wb_ready=0, one pop, count 3, next cycle accept.
REQ-035 Push idx=17 data=1 then idx=17 data=2 -> rf writes 1 then 2; busy[17] clears only after second pop.
REQ-036 Push idx=20 -> no rf_we, bad_idx=1 and stays 1 through flush; clears only on reset.
REQ-037 Three entries queued, assert reset low mid-drain -> rf_we=0, busy=0 immediately; after release, queue empty, wb_ready=1.

Source files
------------

// File: rtl/regwb_queue_pkg.sv
// Shared CPU definitions for the writeback path: register index map and queue entry layout.
package regwb_queue_pkg;

    localparam int IDX_W  = 5;
    localparam int DATA_W = 64;

    localparam logic [IDX_W-1:0] G0  = 5'd0;
    localparam logic [IDX_W-1:0] G1  = 5'd1;
    localparam logic [IDX_W-1:0] G2  = 5'd2;
    localparam logic [IDX_W-1:0] G3  = 5'd3;
    localparam logic [IDX_W-1:0] G4  = 5'd4;
    localparam logic [IDX_W-1:0] G5  = 5'd5;
    localparam logic [IDX_W-1:0] G6  = 5'd6;
    localparam logic [IDX_W-1:0] G7  = 5'd7;
    localparam logic [IDX_W-1:0] G8  = 5'd8;
    localparam logic [IDX_W-1:0] G9  = 5'd9;
    localparam logic [IDX_W-1:0] G10 = 5'd10;
    localparam logic [IDX_W-1:0] G11 = 5'd11;
    localparam logic [IDX_W-1:0] G12 = 5'd12;
    localparam logic [IDX_W-1:0] G13 = 5'd13;
    localparam logic [IDX_W-1:0] G14 = 5'd14;
    localparam logic [IDX_W-1:0] G15 = 5'd15;
    localparam logic [IDX_W-1:0] FP  = 5'd16;
    localparam logic [IDX_W-1:0] SP  = 5'd17;
    localparam int               NREGS = 18;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order storage for pending register writes; exposes per-slot validity so the
// top can derive the pending-write bitmap.
module wb_fifo
    import regwb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  wb_entry_t                wr_entry,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         slot_valid,
    output logic [IDX_W-1:0]         slot_idx [DEPTH]
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    wb_entry_t     mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; validity comes solely from the pointers and count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_entry;
    end

    assign head = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = {1'b0, PW'(PW'(i) - rd_ptr)} < count;
            slot_idx[i]   = mem[i].idx;
        end
    end

endmodule

// File: rtl/regwb_queue.sv
// Writeback queue between execute and the register bank, with a pending-write
// bitmap for decode stalls and a sticky flag for out-of-range destinations.
module regwb_queue #(
    parameter int DEPTH = 4,
    parameter int NREGS = regwb_queue_pkg::NREGS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [4:0]       wb_idx,
    input  logic [63:0]      wb_data,
    output logic             rf_we,
    input  logic             rf_ready,
    output logic [4:0]       rf_idx,
    output logic [63:0]      rf_data,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic             bad_idx
);

    import regwb_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count;
    logic [DEPTH-1:0] slot_valid;
    logic [IDX_W-1:0] slot_idx [DEPTH];
    wb_entry_t        head;
    wb_entry_t        wr_entry;
    logic             idx_ok;
    logic             handshake;
    logic             push;
    logic             pop;

    // Reset is folded in so the queue refuses results while held in reset.
    assign wb_ready  = reset && (count != CW'(DEPTH)) && !flush;
    assign idx_ok    = 32'(wb_idx) < NREGS;
    assign handshake = wb_valid && wb_ready;
    assign push      = handshake && idx_ok;
    assign rf_we     = (count != '0);
    assign pop       = rf_we && rf_ready;
    assign wr_entry  = '{idx: wb_idx, data: wb_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .wr_entry   (wr_entry),
        .head       (head),
        .count      (count),
        .slot_valid (slot_valid),
        .slot_idx   (slot_idx)
    );

    assign rf_idx  = rf_we ? head.idx  : '0;
    assign rf_data = rf_we ? head.data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bad_idx <= 1'b0;
        end else if (handshake && !idx_ok) begin
            bad_idx <= 1'b1;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_valid[i] && (slot_idx[i] == 5'(r))) busy[r] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regwb_queue.sv
// Randomized and directed bench for regwb_queue against a queue-based reference model.
module tb_regwb_queue;

    localparam int DEPTH = 4;
    localparam int NREGS = 18;

    logic             clk;
    logic             reset;
    logic             wb_valid;
    logic             wb_ready;
    logic [4:0]       wb_idx;
    logic [63:0]      wb_data;
    logic             rf_we;
    logic             rf_ready;
    logic [4:0]       rf_idx;
    logic [63:0]      rf_data;
    logic             flush;
    logic [NREGS-1:0] busy;
    logic             bad_idx;

    regwb_queue #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data),
        .rf_we    (rf_we),
        .rf_ready (rf_ready),
        .rf_idx   (rf_idx),
        .rf_data  (rf_data),
        .flush    (flush),
        .busy     (busy),
        .bad_idx  (bad_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
    } ent_t;

    ent_t mq[$];
    logic m_bad;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [NREGS-1:0] exp_busy;
        logic             exp_we;
        exp_busy = '0;
        foreach (mq[k]) exp_busy[mq[k].idx] = 1'b1;
        exp_we = (mq.size() != 0);
        check_val("wb_ready", 64'(wb_ready), 64'((mq.size() != DEPTH) && !flush));
        check_val("rf_we",    64'(rf_we),    64'(exp_we));
        check_val("rf_idx",   64'(rf_idx),   exp_we ? 64'(mq[0].idx) : 64'd0);
        check_val("rf_data",  rf_data,       exp_we ? mq[0].data : 64'd0);
        check_val("busy",     64'(busy),     64'(exp_busy));
        check_val("bad_idx",  64'(bad_idx),  64'(m_bad));
    endtask

    // Called just after a falling edge: drive, check the pre-edge view, advance the model.
    task automatic cycle(input logic v, input logic [4:0] idx, input logic [63:0] d,
                         input logic rr, input logic fl);
        logic room;
        logic do_pop;
        wb_valid = v;
        wb_idx   = idx;
        wb_data  = d;
        rf_ready = rr;
        flush    = fl;
        #1;
        check_all();
        if (fl) begin
            mq.delete();
        end else begin
            room   = (mq.size() != DEPTH);
            do_pop = (mq.size() != 0) && rr;
            if (do_pop) void'(mq.pop_front());
            if (v && room) begin
                if (int'(idx) < NREGS) mq.push_back('{idx: idx, data: d});
                else m_bad = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 5'd0, 64'd0, rr, 1'b0);
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        wb_valid = 1'b0;
        wb_idx   = '0;
        wb_data  = '0;
        rf_ready = 1'b0;
        flush    = 1'b0;
        #1;
        mq.delete();
        m_bad = 1'b0;
        check_val("rst_wb_ready", 64'(wb_ready), 64'd0);
        check_val("rst_rf_we",    64'(rf_we),    64'd0);
        check_val("rst_rf_idx",   64'(rf_idx),   64'd0);
        check_val("rst_rf_data",  rf_data,       64'd0);
        check_val("rst_busy",     64'(busy),     64'd0);
        check_val("rst_bad_idx",  64'(bad_idx),  64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        m_bad = 1'b0;
        apply_reset();

        // single push, visible next cycle, busy clears after the pop
        cycle(1'b1, 5'd3, 64'hDEAD, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // fill with the bank stalled, fifth offer refused, then drain in order
        for (int i = 0; i < 5; i++) cycle(1'b1, 5'(i + 4), 64'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // full queue with simultaneous offer and pop, then accepted next cycle
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'(i), 64'(200 + i), 1'b0, 1'b0);
        cycle(1'b1, 5'd9, 64'h999, 1'b1, 1'b0);
        cycle(1'b1, 5'd9, 64'h999, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // two writes to sp stay ordered
        cycle(1'b1, 5'd17, 64'd1, 1'b0, 1'b0);
        cycle(1'b1, 5'd17, 64'd2, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // out-of-range destination is dropped and sticky across flush
        cycle(1'b1, 5'd20, 64'h55, 1'b0, 1'b0);
        cycle(1'b1, 5'd2, 64'h66, 1'b0, 1'b0);
        cycle(1'b1, 5'd5, 64'h77, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // reset in the middle of a drain
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'(i + 10), 64'(300 + i), 1'b0, 1'b0);
        idle(1'b1);
        apply_reset();
        idle(1'b1);

        for (int n = 0; n < 600; n++) begin
            logic [4:0] ridx;
            ridx = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(18, 31))
                                                : 5'($urandom_range(0, 17));
            cycle($urandom_range(0, 3) != 0, ridx, {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
